// File: rtl/fetch_unit.sv
// Instruction fetch front end: one-outstanding-request memory sequencer feeding a small
// instruction FIFO, with redirect flush and halt on ECALL.
//
// state | meaning
// START | first cycle after reset, loads the initial fetch PC
// REQ   | request to memory while the buffer has room
// WAIT  | one request granted, waiting for its read data
// DROP  | granted request was redirected away, discard its read data
// HALT  | ECALL buffered, no further fetches until a redirect
module fetch_unit #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] pc_init_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic        instr_valid_o,
   output logic [31:0] instr_o,
   output logic [31:0] instr_pc_o,
   input  logic        instr_ready_i,
   output logic        halt_o
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0] LAST_C  = PW'(FIFO_DEPTH - 1);
   localparam logic [6:0]    OP_I_ECALL = 7'b1110011;

   localparam logic [2:0] S_START = 3'd0;
   localparam logic [2:0] S_REQ   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_DROP  = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd4;

   logic [2:0]    r_state;
   logic [31:0]   r_fetch_pc;
   logic [31:0]   r_req_pc;
   logic [31:0]   r_mem_instr [FIFO_DEPTH];
   logic [31:0]   r_mem_pc    [FIFO_DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;

   logic [2:0]  w_state_nxt;
   logic [31:0] w_fetch_pc_nxt;
   logic [31:0] w_req_pc_nxt;
   logic        w_req;
   logic        w_grant;
   logic        w_push;
   logic        w_pop;
   logic        w_ecall;
   logic [31:0] w_redir_pc;
   logic [31:0] w_init_pc;
   logic        w_unused_bits;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_C) ? '0 : p + PW'(1);
   endfunction

   assign w_unused_bits = ^{redirect_pc_i[1:0], pc_init_i[1:0]};

   always_comb begin
      w_req      = (r_state == S_REQ) && (r_count < DEPTH_C);
      w_grant    = w_req && imem_gnt_i;
      w_redir_pc = {redirect_pc_i[31:2], 2'b00};
      w_init_pc  = {pc_init_i[31:2], 2'b00};
      // Redirect kills both the word arriving and the word leaving this cycle.
      w_push     = (r_state == S_WAIT) && imem_rvalid_i && !redirect_i;
      w_pop      = (r_count != '0) && instr_ready_i && !redirect_i;
      w_ecall    = (imem_rdata_i[6:0] == OP_I_ECALL);
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_fetch_pc_nxt = r_fetch_pc;
      w_req_pc_nxt   = r_req_pc;
      case (r_state)
         S_START: begin
            w_fetch_pc_nxt = redirect_i ? w_redir_pc : w_init_pc;
            w_state_nxt    = S_REQ;
         end
         S_REQ: begin
            if (w_grant) begin
               w_req_pc_nxt   = r_fetch_pc;
               w_fetch_pc_nxt = r_fetch_pc + 32'd4;
               w_state_nxt    = S_WAIT;
            end
            // A grant in the redirect cycle is still in flight and must be drained.
            if (redirect_i) begin
               w_fetch_pc_nxt = w_redir_pc;
               w_state_nxt    = w_grant ? S_DROP : S_REQ;
            end
         end
         S_WAIT: begin
            if (redirect_i) begin
               w_fetch_pc_nxt = w_redir_pc;
               w_state_nxt    = imem_rvalid_i ? S_REQ : S_DROP;
            end else if (imem_rvalid_i) begin
               w_state_nxt = w_ecall ? S_HALT : S_REQ;
            end
         end
         S_DROP: begin
            if (imem_rvalid_i) begin
               w_state_nxt = S_REQ;
            end
            if (redirect_i) begin
               w_fetch_pc_nxt = w_redir_pc;
            end
         end
         S_HALT: begin
            if (redirect_i) begin
               w_fetch_pc_nxt = w_redir_pc;
               w_state_nxt    = S_REQ;
            end
         end
         default: begin
            w_state_nxt = S_START;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state    <= S_START;
         r_fetch_pc <= '0;
         r_req_pc   <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_fetch_pc <= w_fetch_pc_nxt;
         r_req_pc   <= w_req_pc_nxt;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem_instr[i] <= '0;
            r_mem_pc[i]    <= '0;
         end
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (redirect_i) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem_instr[r_wr_ptr] <= imem_rdata_i;
            r_mem_pc[r_wr_ptr]    <= r_req_pc;
            r_wr_ptr              <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CW'(1);
         end
      end
   end

   assign imem_req_o    = w_req;
   assign imem_addr_o   = r_fetch_pc;
   assign instr_valid_o = (r_count != '0);
   assign instr_o       = r_mem_instr[r_rd_ptr];
   assign instr_pc_o    = r_mem_pc[r_rd_ptr];
   assign halt_o        = (r_state == S_HALT);

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, instruction buffer entries, legal range 2..8.
REQ-002 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-high.
REQ-004 pc_init_i  input  32  start address (word_st), loaded as first fetch PC after reset release.
REQ-005 imem_req_o  output  1  fetch request to instruction memory.
REQ-006 imem_addr_o  output  32  fetch word address, bits [1:0] always 0.
REQ-007 imem_gnt_i  input  1  memory accepts the request in this cycle.
REQ-008 imem_rvalid_i  input  1  read data valid for the oldest granted request.
REQ-009 imem_rdata_i  input  32  fetched instruction word.
REQ-010 redirect_i  input  1  control-flow change from the core; single-cycle pulse.
REQ-011 redirect_pc_i  input  32  new fetch target, valid with redirect_i.
REQ-012 instr_valid_o  output  1  buffer head holds an instruction.
REQ-013 instr_o  output  32  buffer head instruction.
REQ-014 instr_pc_o  output  32  PC of buffer head instruction.
REQ-015 instr_ready_i  input  1  core consumes head when instr_valid_o is also 1.
REQ-016 halt_o  output  1  fetch stopped after an ECALL word was buffered.

Function
REQ-017 The block SHALL implement FSM states START, REQ, WAIT, DROP, HALT.
REQ-018 START: first cycle after reset release, the fetch PC SHALL load pc_init_i, then REQ.
REQ-019 REQ: imem_req_o SHALL be 1 only when buffer occupancy < FIFO_DEPTH; imem_addr_o = fetch PC; both SHALL be held stable until imem_gnt_i.
REQ-020 On req&gnt the block SHALL latch the request PC, advance fetch PC by 4 (modulo 2^32, 0xFFFFFFFC wraps to 0), and enter WAIT.
REQ-021 At most one request SHALL be outstanding; imem_req_o SHALL be 0 in WAIT, DROP, HALT, START.
REQ-022 WAIT: imem_rvalid_i SHALL push {imem_rdata_i, latched PC} into the buffer and return to REQ; rvalid is never earlier than the cycle after gnt.
REQ-023 A pushed word with bits [6:0] = 7'b1110011 (OP_I_ECALL) SHALL move the FSM to HALT instead of REQ.
REQ-024 Buffer is FIFO order; instr_valid_o = occupancy != 0; pop on instr_valid_o & instr_ready_i; push and pop in the same cycle SHALL keep occupancy unchanged.
REQ-025 Outputs instr_o/instr_pc_o SHALL come directly from the head entry (no added latency); fetch-to-output latency is one cycle after rvalid.
REQ-026 redirect_i SHALL flush the buffer (instr_valid_o 0 next cycle, any same-cycle pop discarded), set fetch PC to {redirect_pc_i[31:2], 2'b00}.
REQ-027 redirect_i in REQ/HALT/START: next state REQ; in WAIT with no same-cycle rvalid: DROP; in WAIT with same-cycle rvalid: data discarded, next state REQ.
REQ-028 redirect_i while req asserted and gnt received in the same cycle: that grant SHALL be treated as outstanding, next state DROP.
REQ-029 DROP: the next imem_rvalid_i SHALL be discarded, then REQ; a second redirect in DROP SHALL only update fetch PC.
REQ-030 halt_o SHALL equal (state == HALT); buffer continues draining in HALT.

Reset
REQ-031 rst_i SHALL immediately force state START, occupancy 0, fetch PC 0, imem_req_o 0, instr_valid_o 0, halt_o 0, instr_o 0, instr_pc_o 0.
REQ-032 Reset mid-transaction SHALL abandon any outstanding request; rvalid arriving after reset release and before a new grant SHALL be ignored.

Verification
REQ-033 pc_init_i=0x100, gnt and rvalid one cycle later, ready=1 -> addresses 0x100,0x104,0x108; instr_pc_o matches each word.
REQ-034 instr_ready_i=0, FIFO_DEPTH=2 -> exactly 2 words buffered, imem_req_o drops to 0; ready=1 -> requests resume at next PC.
REQ-035 Word 0x00000073 fetched at 0x10C -> halt_o=1 next cycle, no further imem_req_o, 0x10C still delivered to core.
REQ-036 redirect_i to 0x203 while in WAIT -> following rvalid discarded, next imem_addr_o=0x200, buffer empty.
REQ-037 redirect_i same cycle as rvalid and pop -> neither word delivered, next request at redirect target.
REQ-038 rst_i pulsed while outstanding, pc_init_i=0x40 -> late rvalid ignored, first address 0x40.
